// File: rtl/keypad_matrix_scanner.sv
// 4x4 key matrix scanner with frame-based press/release debounce.
// Drives one column at a time, samples the synchronized rows at the end of
// each column dwell, and evaluates the whole 16-key frame once per scan.
module keypad_matrix_scanner #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int            DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DB         = 4'(DEBOUNCE);

  typedef enum logic [1:0] {IDLE, PRESS_DB, PRESSED, REL_DB} state_t;

  logic [3:0]    row_p0, row_p1;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic          last_dwell, frame_end;
  logic [15:0]   snap, frame_now;
  logic [4:0]    ones;
  logic [3:0]    res_code;
  logic          res_vld;
  state_t        state, state_nx;
  logic [3:0]    cand, cand_nx, cnt, cnt_nx, code_nx;
  logic          valid_nx, held_nx, match_held;

  // Two-flop synchronizer for the asynchronous row lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_p0 <= '0;
      row_p1 <= '0;
    end else begin
      row_p0 <= row;
      row_p1 <= row_p0;
    end
  end

  assign last_dwell = (dwell == DWELL_LAST);
  assign frame_end  = last_dwell && col[3];

  // Column index is the bit position of the one-hot column drive
  always_comb begin
    col_idx = 2'd0;
    case (col)
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_idx = 2'd0;
    endcase
  end

  // Dwell counter and one-hot column rotation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell <= '0;
      col   <= 4'b0001;
    end else if (last_dwell) begin
      dwell <= '0;
      col   <= {col[2:0], col[3]};
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // Capture the settled rows of the driven column into the frame snapshot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
    end else if (last_dwell) begin
      snap[col_idx*4 +: 4] <= row_p1;
    end
  end

  // Frame seen at frame end: the snapshot with the column being sampled now
  // spliced in, so evaluation happens on the same edge as the last capture.
  // Snapshot bit col*4+row maps to key code row*4+col.
  always_comb begin
    frame_now                  = snap;
    frame_now[col_idx*4 +: 4]  = row_p1;
    ones                       = 5'd0;
    res_code                   = 4'd0;
    for (int b = 0; b < 16; b++) begin
      if (frame_now[b]) begin
        ones     = ones + 5'd1;
        res_code = 4'((b % 4) * 4 + (b / 4));
      end
    end
    res_vld    = (ones == 5'd1);
  end

  assign match_held = res_vld && (res_code == key_code);

  // Debounce FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= 4'd0;
      cnt       <= 4'd0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nx;
      cand      <= cand_nx;
      cnt       <= cnt_nx;
      key_code  <= code_nx;
      key_valid <= valid_nx;
      key_held  <= held_nx;
    end
  end

  // Next-state logic; all transitions happen only on the frame-end cycle
  always_comb begin
    state_nx = state;
    cand_nx  = cand;
    cnt_nx   = cnt;
    code_nx  = key_code;
    valid_nx = 1'b0;
    if (frame_end) begin
      case (state)
        IDLE: begin
          if (res_vld) begin
            if (DB == 4'd1) begin
              state_nx = PRESSED;
              code_nx  = res_code;
              valid_nx = 1'b1;
            end else begin
              state_nx = PRESS_DB;
              cand_nx  = res_code;
              cnt_nx   = 4'd1;
            end
          end
        end
        PRESS_DB: begin
          if (!res_vld) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
          end else if (res_code == cand) begin
            if (cnt + 4'd1 == DB) begin
              state_nx = PRESSED;
              code_nx  = cand;
              valid_nx = 1'b1;
              cnt_nx   = 4'd0;
            end else begin
              cnt_nx = cnt + 4'd1;
            end
          end else begin
            cand_nx = res_code;
            cnt_nx  = 4'd1;
          end
        end
        PRESSED: begin
          if (!match_held) begin
            if (DB == 4'd1) begin
              state_nx = IDLE;
              cnt_nx   = 4'd0;
            end else begin
              state_nx = REL_DB;
              cnt_nx   = 4'd1;
            end
          end
        end
        REL_DB: begin
          if (match_held) begin
            state_nx = PRESSED;
            cnt_nx   = 4'd0;
          end else if (cnt + 4'd1 == DB) begin
            state_nx = IDLE;
            cnt_nx   = 4'd0;
          end else begin
            cnt_nx = cnt + 4'd1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
    held_nx = (state_nx == PRESSED) || (state_nx == REL_DB);
  end

endmodule
